sample_queue_param: RTL and testbench

Parametrised circular sample queue feeding the FIR filter bank of the audio equalizer. Stores every DECIM-th stereo (or NCH-channel) sample from the I2S receiver into dual-port RAM. Once TAPS samples are held, each newly accepted sample triggers a burst readout of the newest TAPS samples, oldest first, with a valid strobe aligned to the data. Generalises the fixed 1024-deep, write-every-other, two-channel low-frequency queue to arbitrary depth, tap count, decimation and channel count, and adds flush, overrun and done reporting.

---
 rtl/sample_queue_param.sv | 167 ++++++++++++++++
 tb/tb_sample_queue_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_queue_param.sv
`default_nettype none
// ============================================================================
// Module   : sample_queue_param
// Purpose  : Decimating circular sample queue with TAPS-long burst readout.
// Revision : 1.0 - initial release
// ============================================================================
module sample_queue_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int TAPS   = 1021,
    parameter int DECIM  = 2,
    parameter int NCH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wrt_smpl,
    input  logic [NCH*DATA_W-1:0] smpl_in,
    input  logic                  flush,
    output logic [NCH*DATA_W-1:0] smpl_out,
    output logic                  smpl_vld,
    output logic                  sequencing,
    output logic                  seq_done,
    output logic                  full,
    output logic                  overrun
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int c_DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [c_DEC_W-1:0] c_DEC_LAST = c_DEC_W'(DECIM - 1);
    localparam logic [ADDR_W:0]    c_TAPS     = (ADDR_W + 1)'(TAPS);
    localparam logic [ADDR_W-1:0]  c_TAPS_M1  = ADDR_W'(TAPS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    generate
        if (TAPS < 1 || TAPS > DEPTH - 1) begin : g_bad_taps
            $error("sample_queue_param: TAPS must satisfy 1 <= TAPS <= 2**ADDR_W-1");
        end
        if (DECIM < 1) begin : g_bad_decim
            $error("sample_queue_param: DECIM must be >= 1");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_DEC_W-1:0]    r_dec_cnt;
    logic [ADDR_W-1:0]     r_new_ptr;
    logic [ADDR_W:0]       r_fill;
    logic [ADDR_W:0]       w_fill_nxt;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [ADDR_W-1:0]     r_rd_cnt;
    logic                  r_vld;
    logic                  r_overrun;
    logic [NCH*DATA_W-1:0] r_rd_data;
    logic [NCH*DATA_W-1:0] mem [DEPTH];

    logic w_accept;
    logic w_start;
    logic w_last_rd;
    logic w_rd_en;

    assign w_accept   = wrt_smpl & (r_dec_cnt == c_DEC_LAST);
    assign w_fill_nxt = (r_fill == c_TAPS) ? c_TAPS : r_fill + 1'b1;
    // A burst starts either with the queue already full or on the write that fills it.
    assign w_start    = w_accept & (r_state == S_IDLE) & (w_fill_nxt == c_TAPS);
    assign w_last_rd  = (r_rd_cnt == c_TAPS_M1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start)   w_state_nxt = S_SEQ;
                S_SEQ:   if (w_last_rd) w_state_nxt = S_DRAIN;
                S_DRAIN: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        sequencing = 1'b0;
        seq_done   = 1'b0;
        w_rd_en    = 1'b0;
        case (r_state)
            S_SEQ: begin
                sequencing = 1'b1;
                w_rd_en    = 1'b1;
            end
            S_DRAIN: begin
                sequencing = 1'b1;
                seq_done   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= '0;
            r_new_ptr <= '0;
            r_fill    <= '0;
            r_rd_addr <= '0;
            r_rd_cnt  <= '0;
            r_vld     <= 1'b0;
            r_overrun <= 1'b0;
        end else if (flush) begin
            r_dec_cnt <= '0;
            r_new_ptr <= '0;
            r_fill    <= '0;
            r_rd_cnt  <= '0;
            r_vld     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (wrt_smpl) begin
                r_dec_cnt <= (r_dec_cnt == c_DEC_LAST) ? '0 : r_dec_cnt + 1'b1;
            end
            if (w_accept) begin
                r_new_ptr <= r_new_ptr + 1'b1;
                r_fill    <= w_fill_nxt;
                if (r_state != S_IDLE) begin
                    r_overrun <= 1'b1;
                end
            end
            if (w_start) begin
                r_rd_addr <= r_new_ptr - c_TAPS_M1;
                r_rd_cnt  <= '0;
            end else if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_rd_cnt  <= r_rd_cnt + 1'b1;
            end
            r_vld <= w_rd_en;
        end
    end

    // Sample RAM: one write port, one registered read port; contents survive flush.
    always_ff @(posedge clk) begin
        if (w_accept && !flush) begin
            mem[r_new_ptr] <= smpl_in;
        end
        if (w_rd_en) begin
            r_rd_data <= mem[r_rd_addr];
        end
    end

    assign smpl_out = r_vld ? r_rd_data : '0;
    assign smpl_vld = r_vld;
    assign full     = (r_fill == c_TAPS);
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sample_queue_param.sv
`default_nettype none
// Bench for sample_queue_param: DUT A (NCH=3, DECIM=1) and DUT B (NCH=2, DECIM=2),
// both ADDR_W=4, TAPS=8.
module tb_sample_queue_param;

    typedef struct {
        int val;
        bit burst;
        int first;
        int step;
        bit full;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_wr, a_flush, b_wr, b_flush;
    logic [47:0] a_in, a_out;
    logic [31:0] b_in, b_out;
    logic        a_vld, a_seq, a_done, a_full, a_ovr;
    logic        b_vld, b_seq, b_done, b_full, b_ovr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sample_queue_param #(.DATA_W(16), .ADDR_W(4), .TAPS(8), .DECIM(1), .NCH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .wrt_smpl(a_wr), .smpl_in(a_in), .flush(a_flush),
        .smpl_out(a_out), .smpl_vld(a_vld), .sequencing(a_seq), .seq_done(a_done),
        .full(a_full), .overrun(a_ovr)
    );

    sample_queue_param #(.DATA_W(16), .ADDR_W(4), .TAPS(8), .DECIM(2), .NCH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .wrt_smpl(b_wr), .smpl_in(b_in), .flush(b_flush),
        .smpl_out(b_out), .smpl_vld(b_vld), .sequencing(b_seq), .seq_done(b_done),
        .full(b_full), .overrun(b_ovr)
    );

    // Channel c carries value + 256*c so that any cross-channel mix is visible.
    function automatic logic [47:0] pack(input bit sel, input int v);
        if (sel) return {16'h0, 16'(v + 256), 16'(v)};
        return {16'(v + 512), 16'(v + 256), 16'(v)};
    endfunction

    function automatic logic [47:0] g_out(input bit sel);
        return sel ? {16'h0, b_out} : a_out;
    endfunction
    function automatic logic g_vld(input bit sel);  return sel ? b_vld  : a_vld;  endfunction
    function automatic logic g_seq(input bit sel);  return sel ? b_seq  : a_seq;  endfunction
    function automatic logic g_done(input bit sel); return sel ? b_done : a_done; endfunction
    function automatic logic g_full(input bit sel); return sel ? b_full : a_full; endfunction
    function automatic logic g_ovr(input bit sel);  return sel ? b_ovr  : a_ovr;  endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input int v);
        logic [47:0] p;
        p = pack(sel, v);
        if (sel) begin
            b_wr = 1'b1;
            b_in = p[31:0];
        end else begin
            a_wr = 1'b1;
            a_in = p;
        end
    endtask

    task automatic release_wr();
        a_wr = 1'b0;
        b_wr = 1'b0;
    endtask

    // Called in cycle T+1 of a burst; optionally strobes s_val in cycle T+s_at.
    task automatic check_burst(input bit sel, input int ev[8], input int s_at, input int s_val);
        chk("seq_t1", g_seq(sel), 1);
        chk("vld_t1", g_vld(sel), 0);
        for (int t = 2; t <= 9; t++) begin
            tick();
            release_wr();
            chk("burst_vld", g_vld(sel), 1);
            chk("burst_data", g_out(sel), pack(sel, ev[t-2]));
            chk("burst_done", g_done(sel), (t == 9));
            chk("burst_seq", g_seq(sel), 1);
            if (s_at == t) drive(sel, s_val);
        end
        tick();
        release_wr();
        chk("end_seq", g_seq(sel), 0);
        chk("end_vld", g_vld(sel), 0);
        chk("end_out", g_out(sel), 0);
        chk("end_done", g_done(sel), 0);
    endtask

    task automatic run_vec(input bit sel, input vec_t r);
        int ev[8];
        drive(sel, r.val);
        tick();
        release_wr();
        chk("full", g_full(sel), r.full);
        if (r.burst) begin
            for (int i = 0; i < 8; i++) ev[i] = r.first + i * r.step;
            check_burst(sel, ev, 0, 0);
            repeat (2) tick();
        end else begin
            chk("idle_seq", g_seq(sel), 0);
            chk("idle_vld", g_vld(sel), 0);
            repeat (11) tick();
        end
    endtask

    initial begin
        vec_t tab_a[40];
        vec_t tab_b[20];
        int   ev[8];

        for (int k = 1; k <= 40; k++)
            tab_a[k-1] = '{val: k, burst: (k >= 8), first: k - 7, step: 1, full: (k >= 8)};
        for (int k = 1; k <= 20; k++)
            tab_b[k-1] = '{val: k, burst: (k >= 16 && k % 2 == 0), first: k - 14, step: 2,
                           full: (k >= 16)};

        rst_n = 1'b0; a_wr = 1'b0; b_wr = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
        a_in = '0; b_in = '0;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            chk("rst_seq", g_seq(s[0]), 0);
            chk("rst_vld", g_vld(s[0]), 0);
            chk("rst_out", g_out(s[0]), 0);
            chk("rst_done", g_done(s[0]), 0);
            chk("rst_full", g_full(s[0]), 0);
            chk("rst_ovr", g_ovr(s[0]), 0);
        end
        rst_n = 1'b1;
        tick();

        // Fill, first burst, and wrapping bursts on DUT A
        for (int i = 0; i < 40; i++) run_vec(1'b0, tab_a[i]);
        chk("no_ovr_a", a_ovr, 0);

        // Strobe during SEQ: overrun, no extra burst
        drive(0, 100);
        tick();
        release_wr();
        ev = '{34, 35, 36, 37, 38, 39, 40, 100};
        check_burst(0, ev, 4, 101);
        chk("ovr_set", a_ovr, 1);
        tick();
        chk("no_extra_burst", a_seq, 0);
        tick();
        drive(0, 102);
        tick();
        release_wr();
        ev = '{36, 37, 38, 39, 40, 100, 101, 102};
        check_burst(0, ev, 0, 0);
        chk("ovr_sticky", a_ovr, 1);
        repeat (2) tick();

        // Flush at T+5 of a burst
        drive(0, 103);
        tick();
        release_wr();
        repeat (4) tick();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("flush_seq", a_seq, 0);
        chk("flush_full", a_full, 0);
        chk("flush_vld", a_vld, 0);
        chk("flush_ovr", a_ovr, 0);
        chk("flush_done", a_done, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("flush_no_done", a_done, 0);
            chk("flush_no_seq", a_seq, 0);
        end
        for (int v = 200; v <= 206; v++) begin
            drive(0, v);
            tick();
            release_wr();
            chk("refill_seq", a_seq, 0);
            chk("refill_full", a_full, 0);
            repeat (3) tick();
        end
        drive(0, 207);
        tick();
        release_wr();
        chk("refill_full8", a_full, 1);
        ev = '{200, 201, 202, 203, 204, 205, 206, 207};
        check_burst(0, ev, 0, 0);
        repeat (2) tick();

        // Decimation on DUT B
        for (int i = 0; i < 20; i++) run_vec(1'b1, tab_b[i]);

        // Asynchronous reset mid-burst
        drive(0, 208);
        tick();
        release_wr();
        repeat (3) tick();
        chk("pre_rst_vld", a_vld, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_seq", a_seq, 0);
        chk("arst_vld", a_vld, 0);
        chk("arst_out", a_out, 0);
        chk("arst_done", a_done, 0);
        chk("arst_full", a_full, 0);
        chk("arst_full_b", b_full, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_seq", a_seq, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
